// File: rtl/collision_scheduler.sv
// Round-robin scheduler sharing one wall-map ROM between two sprite collision checkers.
// Each check walks eight bounding-box probes through the ROM and reports whether any hit a wall.
module collision_scheduler #(
  parameter int unsigned TILE   = 10,
  parameter int unsigned SPRITE = 20,
  parameter int unsigned MAP_W  = 64,
  parameter int unsigned MAP_H  = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic [9:0] i_x0,
  input  logic [9:0] i_x1,
  input  logic [8:0] i_y0,
  input  logic [8:0] i_y1,
  output logic [1:0] o_gnt,
  output logic [1:0] o_done,
  output logic       o_blocked,
  output logic       o_busy,
  output logic [5:0] o_rom_x,
  output logic [5:0] o_rom_y,
  input  logic       i_rom_q
);

  localparam logic [10:0] OffA = 11'(SPRITE / 2 - 1);
  localparam logic [10:0] OffB = 11'(SPRITE - 1);

  typedef enum logic [1:0] {StIdle, StProbe, StWait} state_e;

  state_e      r_state;
  logic [2:0]  r_p;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic        r_lp;
  logic        r_acc;
  logic        r_oob;
  logic [1:0]  r_gnt;
  logic [1:0]  r_done;
  logic        r_blocked;
  logic        r_busy;
  logic [5:0]  r_rom_x;
  logic [5:0]  r_rom_y;

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_sx;
  logic [10:0] w_sy;
  logic [10:0] w_tx;
  logic [10:0] w_ty;
  logic        w_oob;
  logic        w_probe_wall;
  logic        w_win;

  // Probe offsets, in issue order, across the sprite's bounding box.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    case (r_p)
      3'd0: begin w_dx = '0;   w_dy = '0;   end
      3'd1: begin w_dx = '0;   w_dy = OffA; end
      3'd2: begin w_dx = '0;   w_dy = OffB; end
      3'd3: begin w_dx = OffA; w_dy = '0;   end
      3'd4: begin w_dx = OffA; w_dy = OffB; end
      3'd5: begin w_dx = OffB; w_dy = '0;   end
      3'd6: begin w_dx = OffB; w_dy = OffA; end
      3'd7: begin w_dx = OffB; w_dy = OffB; end
      default: begin w_dx = '0; w_dy = '0; end
    endcase
  end

  always_comb begin
    w_sx         = {1'b0, r_x} + w_dx;
    w_sy         = {2'b0, r_y} + w_dy;
    w_tx         = w_sx / 11'(TILE);
    w_ty         = w_sy / 11'(TILE);
    w_oob        = (w_tx >= 11'(MAP_W)) || (w_ty >= 11'(MAP_H));
    // r_oob travels alongside the address so it lines up with the ROM data.
    w_probe_wall = ~i_rom_q | r_oob;
  end

  // Tie goes to whoever was not served last.
  always_comb begin
    if (i_req == 2'b11) begin
      w_win = ~r_lp;
    end else begin
      w_win = i_req[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_p       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_lp      <= 1'b1;
      r_acc     <= 1'b0;
      r_oob     <= 1'b0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_blocked <= 1'b0;
      r_busy    <= 1'b0;
      r_rom_x   <= '0;
      r_rom_y   <= '0;
    end else begin
      r_done    <= '0;
      r_blocked <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_en && (i_req != 2'b00)) begin
            r_lp    <= w_win;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_x     <= w_win ? i_x1 : i_x0;
            r_y     <= w_win ? i_y1 : i_y0;
            r_p     <= '0;
            r_acc   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StProbe;
          end
        end
        StProbe: begin
          r_rom_x <= w_tx[5:0];
          r_rom_y <= w_ty[5:0];
          r_oob   <= w_oob;
          r_p     <= r_p + 3'd1;
          // From p=1 on, the ROM answers the previous cycle's probe.
          if (r_p != 3'd0) begin
            r_acc <= r_acc | w_probe_wall;
          end
          if (r_p == 3'd7) begin
            r_state <= StWait;
          end
        end
        StWait: begin
          r_done    <= r_gnt;
          r_blocked <= r_acc | w_probe_wall;
          r_gnt     <= '0;
          r_busy    <= 1'b0;
          r_state   <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_done    = r_done;
  assign o_blocked = r_blocked;
  assign o_busy    = r_busy;
  assign o_rom_x   = r_rom_x;
  assign o_rom_y   = r_rom_y;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with a combinational model of the ROM array
// behind the scheduler's registered address.
module tb_collision_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic [1:0] req = 2'b00;
  logic [9:0] x0 = '0;
  logic [9:0] x1 = '0;
  logic [8:0] y0 = '0;
  logic [8:0] y1 = '0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       blocked;
  logic       busy;
  logic [5:0] rom_x;
  logic [5:0] rom_y;
  logic       rom_q;
  logic       wall_mode = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  collision_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .i_en     (en),
    .i_req    (req),
    .i_x0     (x0),
    .i_x1     (x1),
    .i_y0     (y0),
    .i_y1     (y1),
    .o_gnt    (gnt),
    .o_done   (done),
    .o_blocked(blocked),
    .o_busy   (busy),
    .o_rom_x  (rom_x),
    .o_rom_y  (rom_y),
    .i_rom_q  (rom_q)
  );

  always #5 clk = ~clk;

  // Wall map: all passable, or a single wall at tile (31,6).
  assign rom_q = !(wall_mode && (rom_x == 6'd31) && (rom_y == 6'd6));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Grant, scramble coordinates to prove latching, then expect done/blocked 10 cycles later.
  task automatic do_check(input string tag, input logic [1:0] r, input logic exp_blk);
    req = r;
    tick();
    chk({tag, " gnt"}, gnt, r);
    req = 2'b00;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (8) tick();
    chk({tag, " early done"}, done, 2'b00);
    tick();
    chk({tag, " done"}, done, r);
    chk({tag, " blocked"}, blocked, exp_blk);
    chk({tag, " gnt off"}, gnt, 2'b00);
    tick();
    chk({tag, " done pulse"}, done, 2'b00);
  endtask

  initial begin
    logic [5:0] exp_x [8];
    logic [5:0] exp_y [8];
    exp_x = '{30, 30, 30, 30, 30, 31, 31, 31};
    exp_y = '{5, 5, 6, 5, 6, 5, 5, 6};

    // Reset values
    repeat (2) tick();
    chk("rst gnt", gnt, 2'b00);
    chk("rst done", done, 2'b00);
    chk("rst busy", busy, 1'b0);
    chk("rst rom_x", rom_x, 6'd0);
    rst = 1'b1;
    tick();

    // Single request, address sequence
    x0 = 10'd300; y0 = 9'd50; req = 2'b01;
    tick();
    chk("t1 gnt", gnt, 2'b01);
    chk("t1 busy", busy, 1'b1);
    req = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t1 rom_x p%0d", k), rom_x, exp_x[k]);
      chk($sformatf("t1 rom_y p%0d", k), rom_y, exp_y[k]);
      chk($sformatf("t1 gnt p%0d", k), gnt, 2'b01);
    end
    tick();
    chk("t1 done", done, 2'b01);
    chk("t1 blocked", blocked, 1'b0);
    chk("t1 busy off", busy, 1'b0);
    tick();
    chk("t1 done pulse", done, 2'b00);

    // Held contention alternates from a fresh reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    x0 = 10'd300; y0 = 9'd50; x1 = 10'd300; y1 = 9'd50;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] e;
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      chk($sformatf("rr gnt %0d", i), gnt, e);
      repeat (8) tick();
      tick();
      chk($sformatf("rr done %0d", i), done, e);
    end
    req = 2'b00;
    tick();

    // Wall at (31,6)
    wall_mode = 1'b1;
    x1 = 10'd300; y1 = 9'd50;
    do_check("wall hit", 2'b10, 1'b1);
    x1 = 10'd280; y1 = 9'd50;
    do_check("wall miss", 2'b10, 1'b0);
    wall_mode = 1'b0;

    // Map edges
    x0 = 10'd630; y0 = 9'd50;
    do_check("oob x", 2'b01, 1'b1);
    x0 = 10'd0; y0 = 9'd470;
    do_check("oob y", 2'b01, 1'b1);
    x0 = 10'd620; y0 = 9'd460;
    do_check("edge in", 2'b01, 1'b0);

    // Reset mid-check
    x0 = 10'd300; y0 = 9'd50; req = 2'b01;
    tick();
    req = 2'b00;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("abort gnt", gnt, 2'b00);
    chk("abort busy", busy, 1'b0);
    chk("abort rom_x", rom_x, 6'd0);
    chk("abort rom_y", rom_y, 6'd0);
    repeat (6) tick();
    chk("abort done", done, 2'b00);
    rst = 1'b1;
    x0 = 10'd300; y0 = 9'd50;
    do_check("post abort", 2'b01, 1'b0);

    // Enable gating
    x0 = 10'd300; y0 = 9'd50;
    en = 1'b0; req = 2'b01;
    repeat (3) tick();
    chk("en0 gnt", gnt, 2'b00);
    chk("en0 busy", busy, 1'b0);
    en = 1'b1;
    tick();
    chk("en1 gnt", gnt, 2'b01);
    en = 1'b0; req = 2'b00;
    repeat (9) tick();
    chk("en drop done", done, 2'b01);
    req = 2'b01;
    repeat (3) tick();
    chk("en wait gnt", gnt, 2'b00);
    en = 1'b1;
    tick();
    chk("en resume gnt", gnt, 2'b01);
    req = 2'b00;
    repeat (9) tick();
    chk("en resume done", done, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Time-shares one single-port wall map ROM between the two sprite collision checkers (requester 0 = steve, requester 1 = creeper). Each check probes eight points on a sprite's bounding box and reports whether any of them lands on a wall or outside the map. It replaces sixteen parallel ROM instances with one ROM plus a round-robin scheduler. It sits between the sprite movement controllers and the wall map ROM.

## Interface
- TILE, 10, pixels per map tile; tile index = coordinate / TILE, integer divide.
- SPRITE, 20, sprite edge length in pixels; probe offsets are 0, SPRITE/2-1, SPRITE-1.
- MAP_W, 64, map width in tiles.
- MAP_H, 48, map height in tiles.

Ports (clock and reset first):
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  high = new checks may be granted; low = no new grants, an in-flight check still completes.
- req  in  2  per-requester check request, level, sampled only in IDLE.
- x0, x1  in  10 each  sprite top-left X for requester 0 / 1.
- y0, y1  in  9 each  sprite top-left Y for requester 0 / 1.
- gnt  out  2  one-hot; marks the requester whose check is in flight.
- done  out  2  one-cycle pulse on the served requester's bit.
- blocked  out  1  check result, valid only while done != 0; 1 = at least one probe hit a wall or left the map.
- busy  out  1  high whenever the state is not IDLE.
- rom_x  out  6  tile X address to the wall ROM, registered.
- rom_y  out  6  tile Y address to the wall ROM, registered.
- rom_q  in  1  wall ROM data: 1 = passable, 0 = wall. The ROM is synchronous with fixed 1-cycle latency.

## Operation
- States: IDLE, PROBE, WAIT.
- IDLE:
  - If en=1 and req!=0: pick the winner, latch its x/y, set gnt, set probe index p=0, clear the accumulator, go to PROBE.
  - Otherwise stay in IDLE.
- Arbitration is round-robin over two requesters using a last-served pointer lp.
  - Only one requester active: grant it.
  - Both active: grant the requester that is not lp.
  - lp is updated at grant. After reset lp=1, so requester 0 wins the first tie.
- Probe order p=0..7 uses (dx,dy) offsets, with a = SPRITE/2-1 and b = SPRITE-1:
  - p0 (0,0), p1 (0,a), p2 (0,b), p3 (a,0)
  - p4 (a,b), p5 (b,0), p6 (b,a), p7 (b,b)
- Coordinate arithmetic:
  - Sums x+dx and y+dy use 11-bit arithmetic, so there is no wrap.
  - tx = (x+dx)/TILE, ty = (y+dy)/TILE.
  - tx >= MAP_W or ty >= MAP_H sets an out-of-map flag for that probe, which counts as a wall.
  - On an out-of-map probe the address is still issued; rom_x/rom_y carry the low 6 bits.
- PROBE:
  - Each cycle, register the address for probe p and increment p.
  - After p7 is issued, go to WAIT.
- Accumulation: one cycle after each address, acc |= ~rom_q | oob_delayed.
- WAIT: fold in probe 7, then:
  - assert done[gnt] and blocked = final acc;
  - clear gnt;
  - return to IDLE.
- Requests are not queued. A requester still holding req in IDLE after its done is a new request; under contention it loses to the other requester.
- A req that drops during PROBE/WAIT does not abort the check; done still pulses.
- Coordinates are latched at grant. Later x/y changes do not affect the in-flight check.
- en falling mid-check has no effect on that check.

## Timing
- Reset values: state IDLE, gnt=0, done=0, blocked=0, busy=0, rom_x=0, rom_y=0, lp=1, acc=0.
- Asynchronous reset aborts any check in flight; no done is issued for it.
- Edge E (IDLE, req sampled): gnt and busy rise after E.
- Address for probe k is valid after edge E+1+k, for k=0..7.
- rom_q for probe k is sampled at edge E+2+k.
- done/blocked are valid for exactly the one cycle following edge E+9. gnt and busy fall at the same edge.
- Earliest next grant is at edge E+10. Sustained throughput is one check per 10 cycles.
- Latency from request to done is 10 cycles when the scheduler is idle, and 20 cycles when the request loses a tie.

## Test plan
- Reset, then req=01, x0=300, y0=50, all-passable ROM -> gnt=01 for 9 cycles; done=01 10 cycles after request; blocked=0; rom_x/rom_y sequence (30,5),(30,5),(30,6),(30,5),(30,6),(31,5),(31,5),(31,6).
- ROM wall only at tile (31,6), req=10, x1=300, y1=50 -> done=10, blocked=1. Moving to x1=280 -> blocked=0.
- req=11 held continuously after reset -> grants alternate 01,10,01,10; done pulses 10 cycles apart; no requester is served twice in a row.
- x0=630, y0=50 -> probe tx=64 is out of map -> blocked=1 even with an all-passable ROM.
- Deassert rst at PROBE p=4 -> all outputs zero at once, no done; a fresh req=01 completes normally in 10 cycles.
- en=0 with req=01 -> no grant, busy=0. Drop en during PROBE -> that check still completes; the next request waits for en=1.
